lsu_master: RTL and testbench
=============================

Name: lsu_master

Overview:
- Load/store initiator that sits between the execute/memory pipeline stage and the data port of the unified memory.
- Accepts one load or store per handshake from the pipeline and drives the memory data port (request/we/addr/data/op).
- Captures load data and returns a response with an error flag to the pipeline.
- Keeps load and store event counters.
- Memory read data is combinational from the address. Memory writes take effect on the clock edge that closes the access cycle.

Parameters:
ADDR_WIDTH, 32, address width of request and memory port
DATA_WIDTH, 32, data width
MEM_BYTES, 3145728, legal byte range; accesses with addr+size-1 >= MEM_BYTES are errors

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, synchronous, active-low (0 = reset)
req_valid_i  input  1  pipeline request valid
req_ready_o  output  1  lsu can accept a request
req_we_i  input  1  1 = store, 0 = load
req_addr_i  input  ADDR_WIDTH  byte address
req_wdata_i  input  DATA_WIDTH  store data (low bytes used for SB/SH)
req_op_i  input  4  `LB/`LBU/`LH/`LHU/`LW/`SB/`SH/`SW codes from defines.v
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  pipeline consumes response
rsp_rdata_o  output  DATA_WIDTH  load result (0 for stores and errors)
rsp_err_o  output  1  access rejected; no memory access performed
mem_request_o  output  1  memory data-port request
mem_we_o  output  1  memory write enable
mem_addr_o  output  ADDR_WIDTH  memory address
mem_data_o  output  DATA_WIDTH  memory write data
mem_op_o  output  4  memory op code
mem_data_i  input  DATA_WIDTH  memory read data (combinational)
ld_cnt_o  output  32  completed loads without error, wraps at 2^32
st_cnt_o  output  32  completed stores without error, wraps at 2^32

Behaviour:
- Reset (rst_i=0 at a rising edge):
  - State goes to IDLE.
  - rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, counters=0.
  - Registered request fields = 0.
- mem_* outputs are gated by rst_i and by state==ISSUE. While rst_i=0, mem_request_o=mem_we_o=0, mem_addr_o=mem_data_o=0, mem_op_o=0. No write is ever issued during reset.
- req_ready_o = (state==IDLE) | (state==RESP & rsp_ready_i). It is 0 while rst_i=0.
- States:
  - IDLE:
    - On accept, register we, addr, wdata, op.
    - Legal request: go to ISSUE.
    - Illegal request: set rsp_err_o=1 and go to RESP.
  - ISSUE (exactly 1 cycle):
    - mem_request_o=1, mem_we_o=reg_we, mem_addr_o=reg_addr, mem_data_o=reg_wdata, mem_op_o=reg_op.
    - At the closing edge: loads latch mem_data_i into rsp_rdata_o; stores set rsp_rdata_o=0.
    - Set rsp_valid_o=1, increment the matching counter, go to RESP.
  - RESP:
    - rsp_valid_o, rsp_rdata_o, rsp_err_o are held stable until rsp_ready_i=1.
    - On rsp_ready_i=1 with no new accept: go to IDLE and clear rsp_valid_o/rsp_err_o.
    - On rsp_ready_i=1 with a simultaneous accept: go directly to ISSUE (or stay in RESP with the new error).
- Illegal request conditions:
  - op not in the eight codes;
  - req_we_i=1 with a load code, or req_we_i=0 with a store code;
  - out-of-range address.
- Access sizes: LB/LBU/SB = 1, LH/LHU/SH = 2, LW/SW = 4. The range check is computed in ADDR_WIDTH+1 bits to avoid wrap.
- Latency: accept edge N, memory access in cycle N+1, rsp_valid_o high from cycle N+2. Error responses are valid from N+1.
- Peak throughput: one access per 2 cycles with rsp_ready_i tied to 1.
- Store-only state is never retained. Each request gets exactly one response, in order.
- Reset mid-operation:
  - A request in ISSUE at the reset edge does not count.
  - Its write is suppressed by the gating rule.
  - Its response is dropped.

Optional Feature:
MISALIGN_TRAP_EN:
- Defined: LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=0, are illegal. They produce an error response without a memory access.
- Undefined: misaligned accesses are issued unchanged. The memory port merges bytes across the word boundary within its 8-byte window.

Test Plan:
- Reset checks:
  - rst_i=0 for 3 cycles with req_valid_i=1 -> req_ready_o=0, mem_request_o=0, rsp_valid_o=0, ld_cnt_o=st_cnt_o=0.
  - rst_i=0 asserted during ISSUE of SW -> no write occurs, no response, st_cnt_o=0.
- SW addr=0x100 wdata=0xDEADBEEF, then LW addr=0x100:
  - SW: mem_request_o=1/mem_we_o=1 exactly one cycle; rsp_valid_o at N+2 with rdata=0.
  - LW: rsp_rdata_o=0xDEADBEEF; st_cnt_o=1, ld_cnt_o=1.
- SB addr=0x101 wdata=0x000000A5, then LBU addr=0x101 and LB addr=0x101 -> rdata 0x000000A5 and 0xFFFFFFA5.
- Backpressure: rsp_ready_i=0 for 4 cycles after LW -> rsp_valid_o/rsp_rdata_o stable, req_ready_o=0. Raise rsp_ready_i with a new req_valid_i -> next ISSUE in the following cycle.
- Error cases: op=4'hF, LW with req_we_i=1, and LW addr=MEM_BYTES-2 -> each gives rsp_err_o=1 at N+1, mem_request_o never 1, counters unchanged.
- LW addr=0x102:
  - With MISALIGN_TRAP_EN defined: rsp_err_o=1, no memory access.
  - Without it: access issued, rdata = bytes 0x102..0x105.

Source files
------------

// File: rtl/lsu_master.sv
`timescale 1ns/1ps
// lsu_master: load/store initiator between the execute/memory stage and the
// data port of the unified memory. One request in flight; each request
// takes IDLE -> ISSUE (one memory cycle) -> RESP, or IDLE -> RESP for a
// rejected request. Load/store completion counters wrap at 2^32.
// Optional build macro: MISALIGN_TRAP_EN rejects misaligned halfword/word
// accesses instead of issuing them to the memory port.
module lsu_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_BYTES  = 3145728
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [3:0]            req_op_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  mem_request_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic [3:0]            mem_op_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [31:0]           ld_cnt_o,
    output logic [31:0]           st_cnt_o
);

    // Memory op codes shared with the pipeline and the memory port.
    localparam logic [3:0] OP_LB  = 4'h0;
    localparam logic [3:0] OP_LH  = 4'h1;
    localparam logic [3:0] OP_LW  = 4'h2;
    localparam logic [3:0] OP_LBU = 4'h4;
    localparam logic [3:0] OP_LHU = 4'h5;
    localparam logic [3:0] OP_SB  = 4'h8;
    localparam logic [3:0] OP_SH  = 4'h9;
    localparam logic [3:0] OP_SW  = 4'hA;

    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);
    localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                state_q;
    state_t                state_d;

    logic                  reg_we;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] reg_wdata;
    logic [3:0]            reg_op;

    logic                  op_known;
    logic                  op_store;
    logic [2:0]            op_size;
    logic [ADDR_WIDTH:0]   size_ext;
    logic [ADDR_WIDTH:0]   last_byte;
    logic                  in_range;
    logic                  misaligned;
    logic                  req_legal;
    logic                  accept;

    // Decode the incoming op into access size and direction.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves one unassigned and infers a latch.
        op_known = 1'b1;
        op_store = 1'b0;
        op_size  = 3'd1;
        case (req_op_i)
            OP_LB, OP_LBU: op_size = 3'd1;
            OP_LH, OP_LHU: op_size = 3'd2;
            OP_LW:         op_size = 3'd4;
            OP_SB: begin op_size = 3'd1; op_store = 1'b1; end
            OP_SH: begin op_size = 3'd2; op_store = 1'b1; end
            OP_SW: begin op_size = 3'd4; op_store = 1'b1; end
            default:       op_known = 1'b0;
        endcase
    end

    // Last touched byte in one extra bit so an access near the top of the
    // address space cannot wrap back into the legal range.
    assign size_ext  = {{(ADDR_WIDTH-2){1'b0}}, op_size};
    assign last_byte = {1'b0, req_addr_i} + size_ext - ONE;
    assign in_range  = (last_byte < MEM_LIMIT);

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((op_size == 3'd2) && req_addr_i[0]) ||
                        ((op_size == 3'd4) && (req_addr_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign req_legal   = op_known && (op_store == req_we_i) && in_range && !misaligned;
    assign req_ready_o = rst_i && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready_i));
    assign accept      = req_valid_i && req_ready_o;

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: a rejected request goes straight to RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_legal ? ISSUE : RESP;
            ISSUE:   state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = accept ? (req_legal ? ISSUE : RESP) : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory port outputs: live only in ISSUE and never while reset is held.
    always_comb begin
        mem_request_o = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;
        mem_op_o      = 4'h0;
        if (rst_i && (state_q == ISSUE)) begin
            mem_request_o = 1'b1;
            mem_we_o      = reg_we;
            mem_addr_o    = reg_addr;
            mem_data_o    = reg_wdata;
            mem_op_o      = reg_op;
        end
    end

    // Capture request fields on every accepted handshake.
    always_ff @(posedge clk_i) begin
        // NOTE: the request registers are reset as well, so the memory port never presents X fields after reset.
        if (!rst_i) begin
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_op    <= 4'h0;
        end else if (accept) begin
            reg_we    <= req_we_i;
            reg_addr  <= req_addr_i;
            reg_wdata <= req_wdata_i;
            reg_op    <= req_op_i;
        end
    end

    // Response register and completion counters.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            ld_cnt_o    <= 32'd0;
            st_cnt_o    <= 32'd0;
        end else if (state_q == ISSUE) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= reg_we ? '0 : mem_data_i;
            if (reg_we) st_cnt_o <= st_cnt_o + 32'd1;
            else        ld_cnt_o <= ld_cnt_o + 32'd1;
        end else if (accept && !req_legal) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_rdata_o <= '0;
        end else if ((state_q == RESP) && rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu_master.sv
`timescale 1ns/1ps
// Self-checking bench for lsu_master: a byte-array memory device, a
// request-level reference model feeding scoreboard queues, and a monitor
// that checks memory-port cycles and responses as the DUT presents them.
module tb_lsu_master;

    localparam int          AW        = 32;
    localparam int          DW        = 32;
    localparam int unsigned MEM_BYTES = 3145728;

    localparam logic [3:0] LB  = 4'h0;
    localparam logic [3:0] LH  = 4'h1;
    localparam logic [3:0] LW  = 4'h2;
    localparam logic [3:0] LBU = 4'h4;
    localparam logic [3:0] LHU = 4'h5;
    localparam logic [3:0] SB  = 4'h8;
    localparam logic [3:0] SH  = 4'h9;
    localparam logic [3:0] SW  = 4'hA;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic [3:0]    req_op_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          mem_request_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [3:0]    mem_op_o;
    logic [DW-1:0] mem_data_i;
    logic [31:0]   ld_cnt_o;
    logic [31:0]   st_cnt_o;

    lsu_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_BYTES(MEM_BYTES)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_op_i(req_op_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o),
        .mem_request_o(mem_request_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_op_o(mem_op_o), .mem_data_i(mem_data_i),
        .ld_cnt_o(ld_cnt_o), .st_cnt_o(st_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] ld;
        logic [31:0] st;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
    } iss_t;

    rsp_t        rsp_q[$];
    iss_t        iss_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  dev_mem [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    int unsigned ref_ld = 0;
    int unsigned ref_st = 0;
    bit          bp_random = 1'b0;
    bit          bp_force  = 1'b1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (request level) ----------------
    function automatic int unsigned acc_size(input logic [3:0] op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic bit is_store(input logic [3:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic bit model_legal(input logic we, input logic [31:0] addr, input logic [3:0] op);
        int unsigned       sz;
        longint unsigned   last;
        sz = acc_size(op);
        if (sz == 0) return 1'b0;
        if (we != is_store(op)) return 1'b0;
        last = longint'(addr) + longint'(sz) - 1;
        if (last >= longint'(MEM_BYTES)) return 1'b0;
`ifdef MISALIGN_TRAP_EN
        if ((addr % sz) != 0) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [3:0] op);
        logic [63:0] v;
        int unsigned sz;
        sz = acc_size(op);
        v  = 64'd0;
        for (int i = 0; i < int'(sz); i++) v = v | (64'(ref_byte(addr + 32'(i))) << (8 * i));
        if (((op == LB) || (op == LH)) && v[8*sz-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8 * sz));
        return v[31:0];
    endfunction

    task automatic model_push(input logic we, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] op);
        rsp_t r;
        iss_t s;
        if (model_legal(we, addr, op)) begin
            s.we = we; s.op = op; s.addr = addr; s.data = data;
            iss_q.push_back(s);
            if (we) begin
                for (int i = 0; i < int'(acc_size(op)); i++) ref_mem[addr + 32'(i)] = data[8*i +: 8];
                ref_st++;
                r.rdata = 32'd0;
            end else begin
                r.rdata = model_load(addr, op);
                ref_ld++;
            end
            r.err = 1'b0;
        end else begin
            r.rdata = 32'd0;
            r.err   = 1'b1;
        end
        r.ld = ref_ld;
        r.st = ref_st;
        rsp_q.push_back(r);
    endtask

    // ---------------- memory device ----------------
    function automatic logic [7:0] dev_byte(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] dev_read(input logic [31:0] a, input logic [3:0] op);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = dev_byte(a + 32'(i));
        case (op)
            LB:      return {{24{w[7]}}, w[7:0]};
            LBU:     return {24'd0, w[7:0]};
            LH:      return {{16{w[15]}}, w[15:0]};
            LHU:     return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Writes land on the edge that closes the access; read data follows the address.
    always @(posedge clk_i) begin
        if (mem_request_o && mem_we_o)
            for (int i = 0; i < int'(acc_size(mem_op_o)); i++)
                dev_mem[mem_addr_o + 32'(i)] = mem_data_o[8*i +: 8];
        #1 mem_data_i = dev_read(mem_addr_o, mem_op_o);
    end

    // Response-ready driver: random backpressure or a forced level.
    always @(negedge clk_i) begin
        rsp_ready_i = bp_random ? ($urandom_range(0, 3) != 0) : bp_force;
    end

    // ---------------- monitor ----------------
    bit          stalled = 1'b0;
    logic [31:0] prev_rdata;
    logic        prev_err;

    always @(negedge clk_i) begin
        iss_t e;
        rsp_t r;
        #2;
        if (rst_i === 1'b1) begin
            if (mem_request_o) begin
                if (iss_q.size() == 0) check("spurious_mem_request", mem_request_o, 1'b0);
                else begin
                    e = iss_q.pop_front();
                    check("mem_addr", mem_addr_o, e.addr);
                    check("mem_data", mem_data_o, e.data);
                    check("mem_we_op", {mem_we_o, mem_op_o}, {e.we, e.op});
                end
            end
            if (stalled) begin
                check("hold_valid", rsp_valid_o, 1'b1);
                check("hold_rdata", rsp_rdata_o, prev_rdata);
                check("hold_err", rsp_err_o, prev_err);
            end
            if (rsp_valid_o && rsp_ready_i) begin
                if (rsp_q.size() == 0) check("spurious_response", rsp_valid_o, 1'b0);
                else begin
                    r = rsp_q.pop_front();
                    check("rsp_rdata", rsp_rdata_o, r.rdata);
                    check("rsp_err", rsp_err_o, r.err);
                    check("ld_cnt", ld_cnt_o, r.ld);
                    check("st_cnt", st_cnt_o, r.st);
                end
            end
            stalled    = rsp_valid_o && !rsp_ready_i;
            prev_rdata = rsp_rdata_o;
            prev_err   = rsp_err_o;
        end else begin
            stalled = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    // Drive a request (caller is in the low clock phase) and hold until accepted.
    task automatic issue_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] op);
        int waited;
        waited      = 0;
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = data;
        req_op_i    = op;
        #1;
        while (!req_ready_o && waited < 200) begin
            @(negedge clk_i);
            #1;
            waited++;
        end
        if (!req_ready_o) begin
            check("accept_timeout", req_ready_o, 1'b1);
            req_valid_i = 1'b0;
        end else begin
            model_push(we, addr, data, op);
            @(posedge clk_i);
            #1 req_valid_i = 1'b0;
        end
    endtask

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] op);
        @(negedge clk_i);
        issue_req(we, addr, data, op);
    endtask

    // Cycle-accurate view of one request just accepted, with rsp_ready_i held high.
    task automatic timed(input string nm, input bit exp_err, input logic [31:0] exp_rdata);
        @(negedge clk_i);
        #2;
        if (exp_err) begin
            check({nm, "_err_valid_n1"}, rsp_valid_o, 1'b1);
            check({nm, "_err_flag_n1"}, rsp_err_o, 1'b1);
            check({nm, "_no_mem_req"}, mem_request_o, 1'b0);
            check({nm, "_err_rdata"}, rsp_rdata_o, 32'd0);
        end else begin
            check({nm, "_mem_req_n1"}, mem_request_o, 1'b1);
            check({nm, "_no_valid_n1"}, rsp_valid_o, 1'b0);
            @(negedge clk_i);
            #2;
            check({nm, "_mem_req_n2"}, mem_request_o, 1'b0);
            check({nm, "_valid_n2"}, rsp_valid_o, 1'b1);
            check({nm, "_rdata_n2"}, rsp_rdata_o, exp_rdata);
        end
    endtask

    logic [3:0] ops [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

    initial begin
        int t;
        rst_i       = 1'b0;
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 32'h100;
        req_wdata_i = 32'h1234_5678;
        req_op_i    = SW;

        // Reset held with a pending request.
        repeat (3) begin
            @(negedge clk_i);
            #2;
            check("rst_req_ready", req_ready_o, 1'b0);
            check("rst_mem_request", mem_request_o, 1'b0);
            check("rst_rsp_valid", rsp_valid_o, 1'b0);
            check("rst_ld_cnt", ld_cnt_o, 32'd0);
            check("rst_st_cnt", st_cnt_o, 32'd0);
        end
        @(negedge clk_i);
        rst_i       = 1'b1;
        req_valid_i = 1'b0;

        // Store then load back.
        send(1'b1, 32'h100, 32'hDEAD_BEEF, SW);
        timed("sw", 1'b0, 32'd0);
        send(1'b0, 32'h100, 32'd0, LW);
        timed("lw", 1'b0, 32'hDEAD_BEEF);
        check("lw_ld_cnt", ld_cnt_o, 32'd1);
        check("lw_st_cnt", st_cnt_o, 32'd1);

        // Byte store, zero- and sign-extended byte loads.
        send(1'b1, 32'h101, 32'h0000_00A5, SB);
        timed("sb", 1'b0, 32'd0);
        send(1'b0, 32'h101, 32'd0, LBU);
        timed("lbu", 1'b0, 32'h0000_00A5);
        send(1'b0, 32'h101, 32'd0, LB);
        timed("lb", 1'b0, 32'hFFFF_FFA5);

        // Backpressure: response held, then released together with a new request.
        bp_force = 1'b0;
        send(1'b0, 32'h100, 32'd0, LW);
        @(negedge clk_i);
        repeat (4) begin
            @(negedge clk_i);
            #2;
            check("bp_valid", rsp_valid_o, 1'b1);
            check("bp_rdata", rsp_rdata_o, 32'hDEAD_A5EF);
            check("bp_req_ready", req_ready_o, 1'b0);
        end
        bp_force = 1'b1;
        send(1'b0, 32'h104, 32'd0, LW);
        @(negedge clk_i);
        #2;
        check("bp_next_issue", mem_request_o, 1'b1);

        // Rejected requests and the top-of-memory boundary.
        send(1'b0, 32'h100, 32'd0, 4'hF);
        timed("bad_op", 1'b1, 32'd0);
        send(1'b1, 32'h100, 32'd0, LW);
        timed("lw_we", 1'b1, 32'd0);
        send(1'b0, 32'(MEM_BYTES - 2), 32'd0, LW);
        timed("lw_oob", 1'b1, 32'd0);
        send(1'b0, 32'(MEM_BYTES - 4), 32'd0, LW);
        timed("lw_top", 1'b0, 32'd0);

        // Misaligned word load.
        send(1'b0, 32'h102, 32'd0, LW);
`ifdef MISALIGN_TRAP_EN
        timed("lw_mis", 1'b1, 32'd0);
`else
        timed("lw_mis", 1'b0, 32'h0000_DEAD);
`endif

        // Reset while a store is in ISSUE.
        @(negedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 32'h300;
        req_wdata_i = 32'hCAFE_F00D;
        req_op_i    = SW;
        #1 check("midrst_ready", req_ready_o, 1'b1);
        begin
            iss_t s;
            s.we = 1'b1; s.op = SW; s.addr = 32'h300; s.data = 32'hCAFE_F00D;
            iss_q.push_back(s);
        end
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        @(negedge clk_i);
        #3;
        check("midrst_in_issue", mem_request_o, 1'b1);
        rst_i = 1'b0;
        #1 check("midrst_gated", mem_request_o, 1'b0);
        @(negedge clk_i);
        #2;
        check("midrst_st_cnt", st_cnt_o, 32'd0);
        check("midrst_ld_cnt", ld_cnt_o, 32'd0);
        check("midrst_no_rsp", rsp_valid_o, 1'b0);
        ref_ld = 0;
        ref_st = 0;
        rst_i  = 1'b1;
        @(negedge clk_i);
        #2;
        check("midrst_no_write", dev_read(32'h300, SW), 32'd0);
        check("midrst_no_rsp2", rsp_valid_o, 1'b0);
        check("midrst_iss_q", iss_q.size(), 0);

        // Randomized traffic with random backpressure.
        bp_random = 1'b1;
        for (int k = 0; k < 300; k++) begin
            logic [3:0]  op;
            logic        we;
            logic [31:0] addr;
            int unsigned r;
            r  = $urandom_range(0, 19);
            op = ops[$urandom_range(0, 7)];
            if (r == 0) op = 4'($urandom_range(0, 15));
            we = is_store(op);
            if (r == 1) we = ~we;
            case ($urandom_range(0, 9))
                0:       addr = MEM_BYTES - $urandom_range(1, 6);
                1:       addr = $urandom;
                default: addr = 32'h200 + $urandom_range(0, 63);
            endcase
            send(we, addr, $urandom, op);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk_i);
        end

        // Drain outstanding responses.
        t = 0;
        while ((rsp_q.size() != 0 || rsp_valid_o) && t < 2000) begin
            @(negedge clk_i);
            t++;
        end
        check("drain_rsp_q", rsp_q.size(), 0);
        check("drain_iss_q", iss_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
